// File: rtl/weight_update_sequencer.sv
// Sweeps every (layer,row) through backprop_stack and applies w <= w - lr*dc_dw to a local weight store.
// Define GRAD_CLIP_EN to clamp each gradient to [-grad_clip, +grad_clip] before the multiply.
module weight_update_sequencer #(
    parameter int data_size      = 16,
    parameter int size           = 3,
    parameter int max_layer_size = 4,
    parameter int frac_bits      = 8
`ifdef GRAD_CLIP_EN
    ,
    parameter logic signed [data_size-1:0] grad_clip = 16'sh0400
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [31:0]               num_layers,
    input  logic [data_size-1:0]      learning_rate,
    output logic                      cal_dc_dw,
    output logic [31:0]               dc_dw_layer,
    output logic [31:0]               dc_dw_row,
    input  logic [data_size*size-1:0] dc_dw_stream,
    input  logic                      wr_en,
    input  logic [31:0]               wr_layer,
    input  logic [31:0]               wr_row,
    input  logic [data_size*size-1:0] wr_data,
    input  logic [31:0]               rd_layer,
    input  logic [31:0]               rd_row,
    output logic [data_size*size-1:0] rd_data,
    output logic                      busy,
    output logic                      done
);

    localparam int LAYER_W  = (max_layer_size > 1) ? $clog2(max_layer_size) : 1;
    localparam int ROW_W    = (size > 1) ? $clog2(size) : 1;
    localparam int ROW_BITS = data_size * size;

    typedef logic signed [data_size-1:0]   elem_t;
    typedef logic signed [2*data_size-1:0] prod_t;
    typedef logic signed [2*data_size:0]   wide_t;
    typedef logic [LAYER_W-1:0]            layer_t;
    typedef logic [ROW_W-1:0]              row_t;
    typedef logic [ROW_BITS-1:0]           rowdata_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        FINISH
    } state_t;

    localparam row_t   LAST_ROW   = row_t'(size - 1);
    localparam layer_t LAST_LAYER = layer_t'(max_layer_size - 1);
    localparam wide_t  SAT_MAX    = wide_t'({1'b0, {(data_size-1){1'b1}}});
    localparam wide_t  SAT_MIN    = -SAT_MAX - wide_t'(1);

    state_t   state_q, state_d;
    layer_t   layer_q, layer_d;
    row_t     row_q, row_d;
    layer_t   last_layer_q, last_layer_d;
    elem_t    lr_q, lr_d;
    logic     busy_q, busy_d;
    logic     done_q, done_d;
    logic     cal_q, cal_d;
    logic [31:0] dc_layer_q, dc_layer_d;
    logic [31:0] dc_row_q, dc_row_d;
    rowdata_t rd_data_q;
    rowdata_t rows_q [max_layer_size][size];

    rowdata_t cur_row;
    rowdata_t upd_row;
    logic     start_take;
    logic     wr_ok;
    logic     rd_ok;

    // One element of the descent step: optional clamp, full product, floor shift, saturating subtract.
    function automatic elem_t step_elem(input elem_t w, input elem_t g_in, input elem_t lr);
        elem_t g;
        prod_t p;
        prod_t q;
        wide_t n;
        g = g_in;
`ifdef GRAD_CLIP_EN
        if (g > grad_clip) begin
            g = grad_clip;
        end else if (g < -grad_clip) begin
            g = -grad_clip;
        end
`endif
        p = prod_t'(lr) * prod_t'(g);
        q = p >>> frac_bits;
        n = wide_t'(w) - wide_t'(q);
        if (n > SAT_MAX) begin
            n = SAT_MAX;
        end else if (n < SAT_MIN) begin
            n = SAT_MIN;
        end
        step_elem = elem_t'(n);
    endfunction

    assign start_take = (state_q == IDLE) && start;

    always_comb begin
        state_d      = state_q;
        layer_d      = layer_q;
        row_d        = row_q;
        last_layer_d = last_layer_q;
        lr_d         = lr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    lr_d    = elem_t'(learning_rate);
                    layer_d = '0;
                    row_d   = '0;
                    if (num_layers == 32'd0) begin
                        state_d = FINISH;
                    end else begin
                        state_d      = ISSUE;
                        last_layer_d = (num_layers >= 32'(max_layer_size)) ? LAST_LAYER
                                                                           : layer_t'(num_layers - 32'd1);
                    end
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                if (row_q != LAST_ROW) begin
                    row_d   = row_q + row_t'(1);
                    state_d = ISSUE;
                end else if (layer_q != last_layer_q) begin
                    row_d   = '0;
                    layer_d = layer_q + layer_t'(1);
                    state_d = ISSUE;
                end else begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with the state they describe.
        cal_d      = (state_d == ISSUE);
        busy_d     = (state_d == ISSUE) || (state_d == CAPTURE);
        done_d     = (state_d == FINISH);
        dc_layer_d = cal_d ? 32'(layer_d) : dc_layer_q;
        dc_row_d   = cal_d ? 32'(row_d) : dc_row_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            layer_q      <= '0;
            row_q        <= '0;
            last_layer_q <= '0;
            lr_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cal_q        <= 1'b0;
            dc_layer_q   <= '0;
            dc_row_q     <= '0;
        end else begin
            state_q      <= state_d;
            layer_q      <= layer_d;
            row_q        <= row_d;
            last_layer_q <= last_layer_d;
            lr_q         <= lr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cal_q        <= cal_d;
            dc_layer_q   <= dc_layer_d;
            dc_row_q     <= dc_row_d;
        end
    end

    // The gradient row registered by backprop_stack is valid during CAPTURE.
    always_comb begin
        cur_row = rows_q[layer_q][row_q];
        upd_row = '0;
        for (int c = 0; c < size; c++) begin
            upd_row[(size-1-c)*data_size +: data_size] = step_elem(
                elem_t'(cur_row[(size-1-c)*data_size +: data_size]),
                elem_t'(dc_dw_stream[(size-1-c)*data_size +: data_size]),
                lr_q);
        end
    end

    assign wr_ok = wr_en && !busy_q && !start_take &&
                   (wr_layer < 32'(max_layer_size)) && (wr_row < 32'(size));
    assign rd_ok = (rd_layer < 32'(max_layer_size)) && (rd_row < 32'(size));

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int l = 0; l < max_layer_size; l++) begin
                for (int r = 0; r < size; r++) begin
                    rows_q[l][r] <= '0;
                end
            end
            rd_data_q <= '0;
        end else begin
            if (state_q == CAPTURE) begin
                rows_q[layer_q][row_q] <= upd_row;
            end else if (wr_ok) begin
                rows_q[wr_layer[LAYER_W-1:0]][wr_row[ROW_W-1:0]] <= wr_data;
            end
            rd_data_q <= rd_ok ? rows_q[rd_layer[LAYER_W-1:0]][rd_row[ROW_W-1:0]] : '0;
        end
    end

    assign cal_dc_dw   = cal_q;
    assign dc_dw_layer = dc_layer_q;
    assign dc_dw_row   = dc_row_q;
    assign rd_data     = rd_data_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: doc/weight_update_sequencer.md
Name: weight_update_sequencer

Overview:
- Downstream consumer of backprop_stack's dc_dw_stream.
- Walks every (layer, row) pair, drives backprop_stack's cal_dc_dw, dc_dw_layer and dc_dw_row, and captures the returned gradient row.
- Applies a fixed-point gradient-descent step (w <= w - lr*dc_dw) to an internal weight store.
- Exposes the weight store to the forward dense stages through a registered read port.

Parameters:
data_size, 16, width of one signed fixed-point element (matches gdo_size)
size, 3, elements per row and rows per layer
max_layer_size, 4, number of layers held in the weight store
frac_bits, 8, fractional bits of the fixed-point format (Q(data_size-frac_bits).frac_bits)

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  synchronous, active-low; sampled on posedge clk
start  input  1  one-cycle pulse, begins an update sweep
num_layers  input  32  layers to update this sweep, sampled on accepted start
learning_rate  input  data_size  signed fixed-point lr, sampled on accepted start
cal_dc_dw  output  1  request to backprop_stack
dc_dw_layer  output  32  layer index of request
dc_dw_row  output  32  row index of request
dc_dw_stream  input  data_size*size  gradient row from backprop_stack; element 0 in MSBs
wr_en  input  1  direct weight load (initialisation)
wr_layer  input  32  load layer index
wr_row  input  32  load row index
wr_data  input  data_size*size  load row; element 0 in MSBs
rd_layer  input  32  read layer index
rd_row  input  32  read row index
rd_data  output  data_size*size  registered read row; element 0 in MSBs
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse when the sweep completes

Behaviour:
- Reset (reset==0 at posedge):
  - FSM goes to IDLE.
  - All outputs are 0: cal_dc_dw, busy, done, dc_dw_layer, dc_dw_row, rd_data.
  - Every weight is cleared to 0.
  - Reset mid-sweep aborts immediately with no partial row written and no done pulse.
- FSM states: IDLE, ISSUE, CAPTURE, FINISH.
  - IDLE:
    - On start, latch lr and nl = min(num_layers, max_layer_size); set layer=0, row=0; set busy=1.
    - If nl==0, go to FINISH; otherwise go to ISSUE.
  - ISSUE: cal_dc_dw=1 with dc_dw_layer=layer and dc_dw_row=row; go to CAPTURE.
  - CAPTURE:
    - cal_dc_dw=0. backprop_stack has registered dc_dw, so dc_dw_stream is valid this cycle (1-cycle latency).
    - Update all size weights of weights[layer][row] in the same edge.
    - If row<size-1: row++, go to ISSUE.
    - Else if layer<nl-1: row=0, layer++, go to ISSUE.
    - Else go to FINISH.
  - FINISH: done=1 for exactly one cycle, busy=0, go to IDLE.
- Sweep timing: the sweep takes 2*nl*size cycles from the ISSUE entry, then 1 FINISH cycle. With the defaults and nl=4, done asserts 25 cycles after the start edge.
- dc_dw_layer and dc_dw_row hold their last issued values outside ISSUE.
- Arithmetic, per element c:
  - p = learning_rate * g[c] as a full 2*data_size signed product.
  - q = p >>> frac_bits, arithmetic shift, truncation toward -inf.
  - n = w - q computed at 2*data_size+1 bits.
  - n saturates to [-(2^(data_size-1)), 2^(data_size-1)-1].
- start while busy is ignored. start in the same cycle as FINISH is ignored.
- wr_en:
  - Honoured only when busy==0 and the IDLE start condition is not taken that cycle.
  - Otherwise dropped silently.
  - An out-of-range wr_layer (>= max_layer_size) or wr_row (>= size) is dropped.
- Read port:
  - rd_data <= weights[rd_layer][rd_row] every cycle, giving 1-cycle latency.
  - Out-of-range indices return 0.
  - Same-cycle write and read of one row returns the old value.

Optional Feature:
GRAD_CLIP_EN
- Defined: a parameter grad_clip (default 16'sh0400) is added. Each g[c] is clamped to [-grad_clip, +grad_clip] before multiplication.
- Undefined: gradients are used unmodified and the grad_clip parameter does not exist.

Test Plan:
- Reset, wr_en loads layer0 row0 = {0x0100,0x0100,0x0100}, rd_layer=0/rd_row=0 -> rd_data = 0x0100_0100_0100 one cycle later.
- start with num_layers=1, lr=0x0080, stream model returns 0x0200 for all rows -> cal_dc_dw pulses at rows 0,1,2 on alternate cycles; done after 7 cycles; layer0 row0 reads {0,0,0}; rows1-2 read 0xFF00 (from 0).
- w=0x7F00, lr=0x0100, g=0xFE00 (-512) -> weight saturates to 0x7FFF; w=0x8100, g=0x0200 -> 0x8000.
- num_layers=0 -> done one cycle after start, cal_dc_dw never asserted. num_layers=9 -> 4 layers swept, 24 requests, dc_dw_layer never exceeds 3.
- start and wr_en pulsed mid-sweep -> both ignored, request sequence and final weights unchanged. reset low mid-sweep -> busy=0 next cycle, no done, all weights read 0.
- GRAD_CLIP_EN defined, g=0x7000, lr=0x0100, w=0 -> w=0xFC00. Undefined -> w=0x9000.
